// File: rtl/trigger_pattern_gen_if.sv
// Trigger pattern generator port bundle: write port, playback control and the driven bus.
// PATGEN_LOOP_EN adds the loop control input.
interface trigger_pattern_gen_if #(
  parameter int WIDTH  = 10,
  parameter int DEPTH  = 8,
  parameter int HOLD_W = 4
) ();
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  // All controls are single-cycle strobes sampled on posedge clk; there is no
  // backpressure. start/wrEn are honoured only while busy=0, abort only while busy=1.
  logic              wrEn;
  logic [AW-1:0]     wrAddr;
  logic [WIDTH-1:0]  wrData;
  logic [HOLD_W-1:0] wrHold;
  logic              start;
  logic [LW-1:0]     startLen;
  logic              abort;
`ifdef PATGEN_LOOP_EN
  logic              loop;
`endif
  logic [WIDTH-1:0]  outBus;
  logic              busy;
  logic              done;
  logic              state_dbg;

  modport master (
    output wrEn, wrAddr, wrData, wrHold, start, startLen, abort,
`ifdef PATGEN_LOOP_EN
    output loop,
`endif
    input  outBus, busy, done, state_dbg
  );

  modport slave (
    input  wrEn, wrAddr, wrData, wrHold, start, startLen, abort,
`ifdef PATGEN_LOOP_EN
    input  loop,
`endif
    output outBus, busy, done, state_dbg
  );
endinterface

// File: rtl/trigger_pattern_gen.sv
// Plays a stored sequence of words onto outBus, each held hold+1 cycles.
// Define PATGEN_LOOP_EN to allow wrapping from the last entry back to entry 0.
module trigger_pattern_gen #(
  parameter int WIDTH  = 10,
  parameter int DEPTH  = 8,
  parameter int HOLD_W = 4
) (
  input logic             clk,
  input logic             rst,
  trigger_pattern_gen_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   typedef enum logic {IDLE = 1'b0, PLAY = 1'b1} state_t;

   state_t            state_q, state_d;
   logic [AW-1:0]     idx_q, idx_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic [LW-1:0]     len_q, len_d;
   logic [WIDTH-1:0]  out_q, out_d;
   logic              done_q, done_d;

   logic [WIDTH-1:0]  mem_data [DEPTH];
   logic [HOLD_W-1:0] mem_hold [DEPTH];

   logic              loop_en;
   logic              start_ok;
   logic              last_entry;
   logic [AW-1:0]     idx_inc;

`ifdef PATGEN_LOOP_EN
   assign loop_en = bus.loop;
`else
   assign loop_en = 1'b0;
`endif

   assign start_ok   = bus.start && !bus.abort && (bus.startLen != '0) &&
                       (bus.startLen <= LW'(DEPTH));
   assign last_entry = ({1'b0, idx_q} == (len_q - LW'(1)));
   assign idx_inc    = idx_q + AW'(1);

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      hold_d  = hold_q;
      len_d   = len_q;
      out_d   = out_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            // Memory is read combinationally here, so a same-cycle write lands after this fetch.
            if (start_ok) begin
               state_d = PLAY;
               idx_d   = '0;
               len_d   = bus.startLen;
               out_d   = mem_data[0];
               hold_d  = mem_hold[0];
            end
         end
         PLAY: begin
            if (bus.abort) begin
               state_d = IDLE;
               idx_d   = '0;
               hold_d  = '0;
               out_d   = '0;
            end else if (hold_q != '0) begin
               hold_d = hold_q - HOLD_W'(1);
            end else if (last_entry) begin
               if (loop_en) begin
                  idx_d  = '0;
                  out_d  = mem_data[0];
                  hold_d = mem_hold[0];
               end else begin
                  state_d = IDLE;
                  idx_d   = '0;
                  out_d   = '0;
                  done_d  = 1'b1;
               end
            end else begin
               idx_d  = idx_inc;
               out_d  = mem_data[idx_inc];
               hold_d = mem_hold[idx_inc];
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         hold_q  <= '0;
         len_q   <= '0;
         out_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         hold_q  <= hold_d;
         len_q   <= len_d;
         out_q   <= out_d;
         done_q  <= done_d;
      end
   end

   // Pattern memory is deliberately not reset; writes are locked out during playback.
   always_ff @(posedge clk) begin
      if (bus.wrEn && (state_q == IDLE)) begin
         mem_data[bus.wrAddr] <= bus.wrData;
         mem_hold[bus.wrAddr] <= bus.wrHold;
      end
   end

   assign bus.outBus    = out_q;
   assign bus.busy      = (state_q == PLAY);
   assign bus.done      = done_q;
   assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_trigger_pattern_gen.sv
// Directed bench for trigger_pattern_gen; expected values are hand-computed per step.
module tb_trigger_pattern_gen;
  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  trigger_pattern_gen_if #(.WIDTH(10), .DEPTH(8), .HOLD_W(4)) bus ();

  trigger_pattern_gen #(.WIDTH(10), .DEPTH(8), .HOLD_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cyc(input string tag, input logic [9:0] b, input logic bz, input logic dn);
    chk({tag, ".bus"},  16'(bus.outBus), 16'(b));
    chk({tag, ".busy"}, 16'(bus.busy),   16'(bz));
    chk({tag, ".done"}, 16'(bus.done),   16'(dn));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [9:0] d, input logic [3:0] h);
    bus.wrEn = 1'b1; bus.wrAddr = a; bus.wrData = d; bus.wrHold = h;
    tick();
    bus.wrEn = 1'b0;
  endtask

  task automatic start_play(input logic [3:0] len);
    bus.start = 1'b1; bus.startLen = len;
    tick();
    bus.start = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.wrEn = 1'b0; bus.wrAddr = '0; bus.wrData = '0; bus.wrHold = '0;
    bus.start = 1'b1; bus.startLen = 4'd1; bus.abort = 1'b0;
`ifdef PATGEN_LOOP_EN
    bus.loop = 1'b0;
`endif

    // 1: reset with start held high
    tick(); chk_cyc("rst0", 10'h000, 1'b0, 1'b0);
    chk("rst0.state", 16'(bus.state_dbg), 16'd0);
    tick(); chk_cyc("rst1", 10'h000, 1'b0, 1'b0);
    rst = 1'b0; bus.start = 1'b0;
    tick();

    // 2: three entries with holds 0,1,2
    wr(3'd0, 10'h201, 4'd0);
    wr(3'd1, 10'h102, 4'd1);
    wr(3'd2, 10'h088, 4'd2);
    start_play(4'd3);
    chk_cyc("p2.e0",   10'h201, 1'b1, 1'b0);
    chk("p2.state", 16'(bus.state_dbg), 16'd1);
    tick(); chk_cyc("p2.e1a", 10'h102, 1'b1, 1'b0);
    tick(); chk_cyc("p2.e1b", 10'h102, 1'b1, 1'b0);
    tick(); chk_cyc("p2.e2a", 10'h088, 1'b1, 1'b0);
    tick(); chk_cyc("p2.e2b", 10'h088, 1'b1, 1'b0);
    tick(); chk_cyc("p2.e2c", 10'h088, 1'b1, 1'b0);
    tick(); chk_cyc("p2.done", 10'h000, 1'b0, 1'b1);
    tick(); chk_cyc("p2.idle", 10'h000, 1'b0, 1'b0);

    // 3: abort on second cycle of entry 1, then a single-entry run
    start_play(4'd3);
    chk_cyc("p3.e0", 10'h201, 1'b1, 1'b0);
    tick(); chk_cyc("p3.e1a", 10'h102, 1'b1, 1'b0);
    tick(); chk_cyc("p3.e1b", 10'h102, 1'b1, 1'b0);
    bus.abort = 1'b1;
    tick(); bus.abort = 1'b0;
    chk_cyc("p3.abort", 10'h000, 1'b0, 1'b0);
    tick(); chk_cyc("p3.nodone", 10'h000, 1'b0, 1'b0);
    start_play(4'd1);
    chk_cyc("p3.r0", 10'h201, 1'b1, 1'b0);
    tick(); chk_cyc("p3.rdone", 10'h000, 1'b0, 1'b1);
    tick(); chk_cyc("p3.ridle", 10'h000, 1'b0, 1'b0);

    // 4: write and start while busy are ignored
    start_play(4'd3);
    chk_cyc("p4.e0", 10'h201, 1'b1, 1'b0);
    bus.wrEn = 1'b1; bus.wrAddr = 3'd1; bus.wrData = 10'h3FF; bus.wrHold = 4'd0;
    bus.start = 1'b1; bus.startLen = 4'd1;
    tick(); bus.wrEn = 1'b0; bus.start = 1'b0;
    chk_cyc("p4.e1a", 10'h102, 1'b1, 1'b0);
    tick(); chk_cyc("p4.e1b", 10'h102, 1'b1, 1'b0);
    tick(); chk_cyc("p4.e2a", 10'h088, 1'b1, 1'b0);
    tick(); tick();
    chk_cyc("p4.e2c", 10'h088, 1'b1, 1'b0);
    tick(); chk_cyc("p4.done", 10'h000, 1'b0, 1'b1);
    start_play(4'd2);
    chk_cyc("p4.r0", 10'h201, 1'b1, 1'b0);
    tick(); chk_cyc("p4.r1a", 10'h102, 1'b1, 1'b0);
    tick(); chk_cyc("p4.r1b", 10'h102, 1'b1, 1'b0);
    tick(); chk_cyc("p4.rdone", 10'h000, 1'b0, 1'b1);
    start_play(4'd0);
    chk_cyc("p4.len0", 10'h000, 1'b0, 1'b0);
    chk("p4.len0.state", 16'(bus.state_dbg), 16'd0);
    tick(); chk_cyc("p4.len0b", 10'h000, 1'b0, 1'b0);
    start_play(4'd9);
    chk_cyc("p4.len9", 10'h000, 1'b0, 1'b0);
    tick(); chk_cyc("p4.len9b", 10'h000, 1'b0, 1'b0);

    // 5: write and start in the same idle cycle; abort handling in idle
    bus.wrEn = 1'b1; bus.wrAddr = 3'd0; bus.wrData = 10'h050; bus.wrHold = 4'd0;
    bus.start = 1'b1; bus.startLen = 4'd1;
    tick(); bus.wrEn = 1'b0; bus.start = 1'b0;
    chk_cyc("p5.old", 10'h201, 1'b1, 1'b0);
    tick(); chk_cyc("p5.done", 10'h000, 1'b0, 1'b1);
    start_play(4'd1);
    chk_cyc("p5.new", 10'h050, 1'b1, 1'b0);
    tick(); chk_cyc("p5.done2", 10'h000, 1'b0, 1'b1);
    bus.abort = 1'b1;
    tick(); chk_cyc("p5.abidle", 10'h000, 1'b0, 1'b0);
    bus.start = 1'b1; bus.startLen = 4'd1;
    tick(); bus.start = 1'b0; bus.abort = 1'b0;
    chk_cyc("p5.stab", 10'h000, 1'b0, 1'b0);
    tick(); chk_cyc("p5.stab2", 10'h000, 1'b0, 1'b0);

`ifdef PATGEN_LOOP_EN
    // 6: looping playback, normal exit, then reset mid-loop
    wr(3'd0, 10'h201, 4'd0);
    bus.loop = 1'b1;
    start_play(4'd2);
    chk_cyc("p6.e0", 10'h201, 1'b1, 1'b0);
    tick(); chk_cyc("p6.e1a", 10'h102, 1'b1, 1'b0);
    tick(); chk_cyc("p6.e1b", 10'h102, 1'b1, 1'b0);
    tick(); chk_cyc("p6.wrap", 10'h201, 1'b1, 1'b0);
    tick(); chk_cyc("p6.w1a", 10'h102, 1'b1, 1'b0);
    tick(); chk_cyc("p6.w1b", 10'h102, 1'b1, 1'b0);
    bus.loop = 1'b0;
    tick(); chk_cyc("p6.done", 10'h000, 1'b0, 1'b1);
    bus.loop = 1'b1;
    start_play(4'd2);
    chk_cyc("p6.l0", 10'h201, 1'b1, 1'b0);
    tick(); chk_cyc("p6.l1", 10'h102, 1'b1, 1'b0);
    rst = 1'b1;
    tick(); rst = 1'b0;
    chk_cyc("p6.rst", 10'h000, 1'b0, 1'b0);
    tick(); chk_cyc("p6.rst2", 10'h000, 1'b0, 1'b0);
    bus.loop = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
